// File: rtl/display_pkg.sv
// Shared constants for the time display: segment codes, mode/cursor encodings
// and the slot ordering of the multiplexed 7-segment display.
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_P     = 8'h73;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [3:0] MODE_TIME_SET = 4'b0001;
    localparam int         NUM_DIGITS    = 7;
    localparam logic [2:0] CURSOR_NONE   = 3'd7;

    // Slot numbering matches the CURSOR encoding of the time-setting block
    typedef enum logic [2:0] {
        SLOT_SEC_ONES  = 3'd0,
        SLOT_SEC_TENS  = 3'd1,
        SLOT_MIN_ONES  = 3'd2,
        SLOT_MIN_TENS  = 3'd3,
        SLOT_HOUR_ONES = 3'd4,
        SLOT_HOUR_TENS = 3'd5,
        SLOT_MERIDIEM  = 3'd6
    } slot_e;

    function automatic logic [7:0] seg_digit(input logic [6:0] d);
        logic [7:0] pattern;
        case (d)
            7'd0:    pattern = SEG_0;
            7'd1:    pattern = SEG_1;
            7'd2:    pattern = SEG_2;
            7'd3:    pattern = SEG_3;
            7'd4:    pattern = SEG_4;
            7'd5:    pattern = SEG_5;
            7'd6:    pattern = SEG_6;
            7'd7:    pattern = SEG_7;
            7'd8:    pattern = SEG_8;
            7'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_bcd_encode.sv
// Binary field (0..127) to two 7-segment digit patterns; values of 100 or more
// show a dash in both digits. Tens are found by restoring compare/subtract.
module seg_bcd_encode
    import display_pkg::*;
(
    input  logic [6:0] value,
    output logic [7:0] tens_seg,
    output logic [7:0] ones_seg
);

    logic [6:0] remainder;
    logic [3:0] tens;

    // Weights 80/40/20/10 give the tens digit in four steps for any value below 100
    always_comb begin
        remainder = value;
        tens      = 4'd0;
        if (remainder >= 7'd80) begin
            remainder = remainder - 7'd80;
            tens      = tens + 4'd8;
        end
        if (remainder >= 7'd40) begin
            remainder = remainder - 7'd40;
            tens      = tens + 4'd4;
        end
        if (remainder >= 7'd20) begin
            remainder = remainder - 7'd20;
            tens      = tens + 4'd2;
        end
        if (remainder >= 7'd10) begin
            remainder = remainder - 7'd10;
            tens      = tens + 4'd1;
        end

        if (value >= 7'd100) begin
            tens_seg = SEG_DASH;
            ones_seg = SEG_DASH;
        end else begin
            tens_seg = seg_digit({3'b000, tens});
            ones_seg = seg_digit(remainder);
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed 7-position time display with per-frame input snapshot and cursor
// highlight. Define CURSOR_BLINK_EN for a blinking cursor digit; otherwise the dp is lit.
module time_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MODE,
    input  logic [2:0] CURSOR,
    input  logic       MERIDIEM,
    input  logic [6:0] HOUR,
    input  logic [6:0] MIN,
    input  logic [6:0] SEC,
    output logic [7:0] SEG,
    output logic [6:0] COM
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0]        LAST_SLOT = 3'(NUM_DIGITS - 1);

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
        $error("time_display_scan: SCAN_DIV and BLINK_DIV must be at least 2");
    end

    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;
    logic              scan_live;

    logic [3:0] snap_mode;
    logic [2:0] snap_cursor;
    logic       snap_meridiem;
    logic [6:0] snap_hour;
    logic [6:0] snap_min;
    logic [6:0] snap_sec;

    logic       advance;
    logic       wrap;
    logic [2:0] idx_next;
    logic [2:0] slot_sel;
    logic [3:0] eff_mode;
    logic [2:0] eff_cursor;
    logic       eff_meridiem;
    logic [6:0] eff_hour;
    logic [6:0] eff_min;
    logic [6:0] eff_sec;
    logic [6:0] field_value;
    logic [7:0] enc_tens;
    logic [7:0] enc_ones;
    logic [7:0] base_pattern;
    logic       cursor_hit;
    logic [7:0] seg_next;

    // On the wrap edge digit 0 is built from the live inputs, i.e. the snapshot being loaded
    always_comb begin
        advance      = (scan_cnt == SCAN_LAST);
        wrap         = advance && (digit_idx == LAST_SLOT);
        idx_next     = wrap ? 3'd0 : digit_idx + 3'd1;
        slot_sel     = advance ? idx_next : digit_idx;
        eff_mode     = wrap ? MODE     : snap_mode;
        eff_cursor   = wrap ? CURSOR   : snap_cursor;
        eff_meridiem = wrap ? MERIDIEM : snap_meridiem;
        eff_hour     = wrap ? HOUR     : snap_hour;
        eff_min      = wrap ? MIN      : snap_min;
        eff_sec      = wrap ? SEC      : snap_sec;

        case (slot_sel)
            SLOT_SEC_ONES, SLOT_SEC_TENS:   field_value = eff_sec;
            SLOT_MIN_ONES, SLOT_MIN_TENS:   field_value = eff_min;
            SLOT_HOUR_ONES, SLOT_HOUR_TENS: field_value = eff_hour;
            default:                        field_value = 7'd0;
        endcase
    end

    seg_bcd_encode u_encode (
        .value    (field_value),
        .tens_seg (enc_tens),
        .ones_seg (enc_ones)
    );

    always_comb begin
        case (slot_sel)
            SLOT_SEC_ONES, SLOT_MIN_ONES, SLOT_HOUR_ONES: base_pattern = enc_ones;
            SLOT_SEC_TENS, SLOT_MIN_TENS, SLOT_HOUR_TENS: base_pattern = enc_tens;
            SLOT_MERIDIEM: base_pattern = eff_meridiem ? SEG_P : SEG_A;
            default:       base_pattern = SEG_BLANK;
        endcase
        cursor_hit = (eff_mode == MODE_TIME_SET) && (eff_cursor != CURSOR_NONE)
                     && (eff_cursor == slot_sel);
    end

`ifdef CURSOR_BLINK_EN
    localparam int                 BLINK_W    = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_cnt_next;
    logic               phase_on;
    logic               phase_next;
    logic [2:0]         cursor_prev;

    // Leaving set mode or moving the cursor restarts the blink with the digit visible
    always_comb begin
        blink_cnt_next = blink_cnt + 1'b1;
        phase_next     = phase_on;
        if ((MODE != MODE_TIME_SET) || (CURSOR != cursor_prev)) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_on;
        end
        seg_next = (cursor_hit && !phase_next) ? SEG_BLANK : base_pattern;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            blink_cnt   <= '0;
            phase_on    <= 1'b1;
            cursor_prev <= CURSOR_NONE;
        end else begin
            blink_cnt   <= blink_cnt_next;
            phase_on    <= phase_next;
            cursor_prev <= CURSOR;
        end
    end
`else
    always_comb begin
        seg_next = {cursor_hit, base_pattern[6:0]};
    end
`endif

    // SEG stays dark until the first slot advance after reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt      <= '0;
            digit_idx     <= LAST_SLOT;
            scan_live     <= 1'b0;
            SEG           <= SEG_BLANK;
            COM           <= 7'h7F;
            snap_mode     <= 4'd0;
            snap_cursor   <= 3'd0;
            snap_meridiem <= 1'b0;
            snap_hour     <= 7'd0;
            snap_min      <= 7'd0;
            snap_sec      <= 7'd0;
        end else begin
            scan_cnt <= advance ? '0 : scan_cnt + 1'b1;
            if (advance) begin
                digit_idx <= idx_next;
                COM       <= ~(7'b0000001 << idx_next);
                scan_live <= 1'b1;
            end
            if (advance || scan_live) begin
                SEG <= seg_next;
            end
            if (wrap) begin
                snap_mode     <= MODE;
                snap_cursor   <= CURSOR;
                snap_meridiem <= MERIDIEM;
                snap_hour     <= HOUR;
                snap_min      <= MIN;
                snap_sec      <= SEC;
            end
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan (SCAN_DIV=4, BLINK_DIV=10); the blink
// sequence runs when CURSOR_BLINK_EN is defined, the steady-dp vectors otherwise.
module tb_time_display_scan;

    typedef struct {
        string       name;
        logic [6:0]  hour;
        logic [6:0]  min;
        logic [6:0]  sec;
        logic        meridiem;
        logic [3:0]  mode;
        logic [2:0]  cursor;
        logic [6:0][7:0] exp_seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] mode = 4'd0;
    logic [2:0] cursor = 3'd7;
    logic       meridiem = 1'b0;
    logic [6:0] hour = 7'd0;
    logic [6:0] min = 7'd0;
    logic [6:0] sec = 7'd0;
    logic [7:0] seg;
    logic [6:0] com;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];
    int   n_vec = 0;

    time_display_scan #(
        .SCAN_DIV  (4),
        .BLINK_DIV (10)
    ) dut (
        .CLK      (clk),
        .RESET    (reset_n),
        .MODE     (mode),
        .CURSOR   (cursor),
        .MERIDIEM (meridiem),
        .HOUR     (hour),
        .MIN      (min),
        .SEC      (sec),
        .SEG      (seg),
        .COM      (com)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] com_of(input int s);
        return ~(7'b0000001 << s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [6:0] h, input logic [6:0] m,
                           input logic [6:0] s, input logic mer, input logic [3:0] md,
                           input logic [2:0] cur, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] s4,
                           input logic [7:0] s5, input logic [7:0] s6);
        vecs[n_vec].name     = name;
        vecs[n_vec].hour     = h;
        vecs[n_vec].min      = m;
        vecs[n_vec].sec      = s;
        vecs[n_vec].meridiem = mer;
        vecs[n_vec].mode     = md;
        vecs[n_vec].cursor   = cur;
        vecs[n_vec].exp_seg  = {s6, s5, s4, s3, s2, s1, s0};
        n_vec++;
    endtask

    task automatic apply_stimulus(input vec_t v);
        hour     = v.hour;
        min      = v.min;
        sec      = v.sec;
        meridiem = v.meridiem;
        mode     = v.mode;
        cursor   = v.cursor;
    endtask

    task automatic check_output(input string name, input logic [7:0] exp_seg,
                                input logic [6:0] exp_com);
        checks++;
        if (seg !== exp_seg || com !== exp_com) begin
            errors++;
            $display("[TB] FAIL %s: got SEG=%h COM=%h, expected SEG=%h COM=%h",
                     name, seg, com, exp_seg, exp_com);
        end
    endtask

    task automatic wait_com(input string name, input logic [6:0] target);
        int n = 0;
        while (com !== target && n < 64) begin
            tick();
            n++;
        end
        if (com !== target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout waiting for COM=%h, got COM=%h", name, target, com);
        end
    endtask

    initial begin
        bit found;

        add_vec("hms_pm", 7'd12, 7'd34, 7'd56, 1'b1, 4'd0, 3'd7,
                8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h73);
        add_vec("dash", 7'd100, 7'd127, 7'd0, 1'b0, 4'd0, 3'd7,
                8'h3F, 8'h3F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h77);
        add_vec("edges", 7'd9, 7'd0, 7'd99, 1'b0, 4'd2, 3'd3,
                8'h6F, 8'h6F, 8'h3F, 8'h3F, 8'h6F, 8'h3F, 8'h77);
        add_vec("set_no_cursor", 7'd23, 7'd45, 7'd8, 1'b1, 4'd1, 3'd7,
                8'h7F, 8'h3F, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h73);
`ifndef CURSOR_BLINK_EN
        add_vec("dp_cursor2", 7'd12, 7'd34, 7'd56, 1'b1, 4'd1, 3'd2,
                8'h7D, 8'h6D, 8'hE6, 8'h4F, 8'h5B, 8'h06, 8'h73);
        add_vec("dp_cursor6", 7'd1, 7'd59, 7'd10, 1'b0, 4'd1, 3'd6,
                8'h3F, 8'h06, 8'h6F, 8'h6D, 8'h06, 8'h3F, 8'hF7);
`endif

        // Reset release and the first full frame, cycle by cycle
        apply_stimulus(vecs[0]);
        reset_n = 1'b0;
        repeat (2) tick();
        check_output("reset_state", 8'h00, 7'h7F);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_output($sformatf("dark_cycle%0d", e), 8'h00, 7'h7F);
        end
        tick();
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < 4; c++) begin
                check_output($sformatf("frame1_slot%0d_cyc%0d", s, c), vecs[0].exp_seg[s], com_of(s));
                tick();
            end
        end

        // Mid-frame SEC change must not tear the current frame
        wait_com("wait_slot3", com_of(3));
        sec = 7'd7;
        wait_com("wait_slot4", com_of(4));
        check_output("tear_slot4", 8'h5B, com_of(4));
        wait_com("wait_slot5", com_of(5));
        check_output("tear_slot5", 8'h06, com_of(5));
        wait_com("wait_slot6", com_of(6));
        check_output("tear_slot6", 8'h73, com_of(6));
        wait_com("wait_slot0", com_of(0));
        check_output("new_sec_ones", 8'h07, com_of(0));
        wait_com("wait_slot1", com_of(1));
        check_output("new_sec_tens", 8'h3F, com_of(1));

        // Asynchronous reset mid-frame, then the restart latency
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check_output("async_reset", 8'h00, 7'h7F);
        tick();
        check_output("reset_held", 8'h00, 7'h7F);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_output($sformatf("restart_dark%0d", e), 8'h00, 7'h7F);
        end
        tick();
        check_output("restart_slot0", 8'h07, com_of(0));

        for (int i = 0; i < n_vec; i++) begin
            apply_stimulus(vecs[i]);
            wait_com("vec_wait_slot6", com_of(6));
            wait_com("vec_wait_slot0", com_of(0));
            check_output($sformatf("%s_slot0", vecs[i].name), vecs[i].exp_seg[0], com_of(0));
            for (int s = 1; s < 7; s++) begin
                repeat (4) tick();
                check_output($sformatf("%s_slot%0d", vecs[i].name, s), vecs[i].exp_seg[s], com_of(s));
            end
        end

`ifdef CURSOR_BLINK_EN
        // Blinking cursor on MIN ones, then a cursor move restarts the blink phase
        apply_stimulus(vecs[0]);
        mode   = 4'd1;
        cursor = 3'd2;
        wait_com("blink_wait_slot6", com_of(6));
        wait_com("blink_wait_slot2", com_of(2));
        found = 1'b0;
        for (int f = 0; f < 4 && !found; f++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (seg !== 8'h66 && seg !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL blink_slot2_value: got SEG=%h, expected 66 or 00", seg);
                end
                if (c < 3 && seg === 8'h00) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            if (!found) repeat (24) tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL blink_seen: got no blanked slot 2, expected SEG=00 within 4 frames");
        end else begin
            cursor = 3'd3;
            tick();
            check_output("blink_restart", 8'h66, com_of(2));
            wait_com("blink_wait_slot6b", com_of(6));
            wait_com("blink_wait_slot2b", com_of(2));
            for (int c = 0; c < 4; c++) begin
                check_output($sformatf("old_cursor_steady%0d", c), 8'h66, com_of(2));
                tick();
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
